lane_masked_ram: RTL
====================

Name: lane_masked_ram

Overview:
- Next-generation single-port block RAM for cell/heap storage.
- Adds a valid/ready request handshake, per-lane write masks, optional output pipeline register, and a hardware clear sequencer that zeroes or fills memory after reset or on command.
- Sits between the memory-access FSM (car/cdr fetch, cons allocation) and the BRAM array.
- One request per cycle; fully pipelined reads.

Parameters:
- ADDR_WIDTH, 8, word address width; depth = 2^ADDR_WIDTH.
- DATA_WIDTH, 32, word width; must be a multiple of LANE_WIDTH.
- LANE_WIDTH, 8, write-mask granularity; NUM_LANES = DATA_WIDTH/LANE_WIDTH.
- OUT_REG, 0, 1 adds an output register stage (read latency 2 instead of 1).
- CLEAR_ON_RESET, 1, 1 runs the clear sequence after reset.
- CLEAR_VALUE, 0, DATA_WIDTH-wide fill value written by the clear sequence.

Ports:
- clk, in, 1, single clock; all logic on posedge.
- rst, in, 1, synchronous active-high reset.
- req_valid, in, 1, request present.
- req_ready, out, 1, request accepted when req_valid && req_ready.
- req_write, in, 1, 1 = write, 0 = read.
- req_addr, in, ADDR_WIDTH, word address.
- req_wdata, in, DATA_WIDTH, write data.
- req_wmask, in, NUM_LANES, bit i enables write of lane i (bits [i*LANE_WIDTH +: LANE_WIDTH]).
- clear_start, in, 1, pulse to begin a clear sequence.
- busy, out, 1, high while clearing.
- rsp_valid, out, 1, one-cycle pulse per accepted read.
- rsp_rdata, out, DATA_WIDTH, read data; holds the last delivered value between pulses.

Behaviour:
- States: CLEAR, IDLE. req_ready = (state == IDLE). busy = (state == CLEAR).
- Reset (rst high at a clock edge):
  - State becomes CLEAR if CLEAR_ON_RESET=1, else IDLE.
  - Clear counter becomes 0.
  - rsp_valid, rsp_rdata and all pipeline valids/data become 0.
  - Memory contents are not touched by reset itself.
- Reset mid-clear restarts clearing at address 0. Reset mid-read discards in-flight responses; no rsp_valid for them.
- CLEAR state:
  - Each cycle, writes CLEAR_VALUE, all lanes, to address = counter, then counter increments.
  - After writing address 2^ADDR_WIDTH-1, transitions to IDLE.
  - Duration is exactly 2^ADDR_WIDTH cycles; req_ready is 0 throughout.
  - clear_start is ignored while in CLEAR.
- IDLE state:
  - clear_start high moves to CLEAR next cycle with counter = 0.
  - A request accepted in the same cycle as clear_start is still executed.
- Write accept:
  - For each lane i with req_wmask[i]=1, that lane of mem[req_addr] is updated at that edge; unmasked lanes are unchanged.
  - A mask of all zeros is a legal no-op.
  - Writes produce no response.
- Read accept at edge T:
  - OUT_REG=0: rsp_valid=1 and rsp_rdata=mem[addr] in the cycle after T (latency 1).
  - OUT_REG=1: the same, one cycle later (latency 2).
  - Read data reflects all writes accepted at edges before T.
  - Back-to-back reads on consecutive cycles produce consecutive rsp_valid pulses, in order.
- No response backpressure: the consumer must take rsp_rdata in the rsp_valid cycle.
- rsp_rdata changes only on a delivered read or on reset. The BRAM read register is enabled only by an accepted read.
- In-flight reads still deliver when a clear starts. Their data is from before the clear.
- req_valid with req_ready=0 has no effect on memory. The requester holds the request until accepted.
- Address wrap: the clear counter is exactly ADDR_WIDTH+1 bits wide for its terminal compare; there is no other wrap.
- Memory array inferred as block RAM, read-first, one port shared by the clear sequencer and requests. The clear sequencer has priority only by state, never in the same cycle.

Test Plan:
- ADDR_WIDTH=4, CLEAR_ON_RESET=1, CLEAR_VALUE=32'hDEADBEEF, rst pulse -> busy=1 and req_ready=0 for exactly 16 cycles. Afterwards, reads of addresses 0,5,15 each return 32'hDEADBEEF with latency 1.
- Write addr 3 data 32'h11223344 mask 4'b1111, then addr 3 data 32'hAABBCCDD mask 4'b0101, then read addr 3 -> rsp_rdata=32'h11BB33DD.
- OUT_REG=1, reads of addresses 1,2,3 on consecutive cycles (pre-written 10,20,30) -> rsp_valid high on 3 consecutive cycles starting 2 cycles after the first accept, data 10,20,30. rsp_rdata holds 30 afterwards.
- Read addr 7 accepted in the same cycle as clear_start (mem[7]=32'h5) -> response 32'h5 delivered. busy rises the next cycle. req_ready=0 for 16 cycles, then mem[7] reads CLEAR_VALUE.
- rst asserted 6 cycles into a clear with a request held pending -> clearing restarts from 0 and runs a full 16 cycles. The pending request is accepted only after busy falls. rsp_valid=0 and rsp_rdata=0 immediately after reset.
- CLEAR_ON_RESET=0 -> req_ready=1 the cycle after reset. Write then read addr 0 returns the written value. A mask of 0 leaves the prior value intact.

Source files
------------

// File: rtl/lane_masked_ram.sv
// rtl/lane_masked_ram.sv - single-port block RAM with per-lane write masks, valid/ready requests and a clear sequencer
module lane_masked_ram #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int LANE_WIDTH     = 8,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_write,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic [DATA_WIDTH-1:0]            req_wdata,
  input  logic [DATA_WIDTH/LANE_WIDTH-1:0] req_wmask,
  input  logic                             clear_start,
  output logic                             busy,
  output logic                             rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata
);

  localparam int NUM_LANES = DATA_WIDTH / LANE_WIDTH;
  localparam int DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CLR_LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;
  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   clr_cnt_q, clr_cnt_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  rd_acc, wr_acc;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [NUM_LANES-1:0]  mem_wmask;

  logic                  rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_data_q;

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_CLEAR);
  assign rd_acc    = req_valid && req_ready && !req_write && !rst;
  assign wr_acc    = req_valid && req_ready &&  req_write && !rst;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + (ADDR_WIDTH + 1)'(1);
        if (clr_cnt_q == CLR_LAST) state_d = ST_IDLE;
      end
      default: begin
        if (clear_start) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RESET_STATE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // The clear sequencer owns the port only while in CLEAR, so the two writers never collide
  always_comb begin
    mem_we    = wr_acc;
    mem_addr  = req_addr;
    mem_wdata = req_wdata;
    mem_wmask = req_wmask;
    if (busy) begin
      mem_we    = !rst;
      mem_addr  = clr_cnt_q[ADDR_WIDTH-1:0];
      mem_wdata = CLEAR_VALUE;
      mem_wmask = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (mem_wmask[l]) mem[mem_addr][l*LANE_WIDTH +: LANE_WIDTH] <= mem_wdata[l*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc) rd_data_q <= mem[req_addr];
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic                  out_valid_q;
      logic [DATA_WIDTH-1:0] out_data_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          out_valid_q <= 1'b0;
          out_data_q  <= '0;
        end else begin
          out_valid_q <= rd_valid_q;
          if (rd_valid_q) out_data_q <= rd_data_q;
        end
      end
      assign rsp_valid = out_valid_q;
      assign rsp_rdata = out_data_q;
    end else begin : g_no_out_reg
      assign rsp_valid = rd_valid_q;
      assign rsp_rdata = rd_data_q;
    end
  endgenerate

endmodule
